sa_mem_loader: RTL and testbench
================================

// Module: sa_mem_loader
// PURPOSE
//  Upstream fill stage for the systolic matmul: accepts an element-wide valid/ready stream and packs
//  it into full memory rows. Writes rows into the weight memory, then the input memory (mem_simple ports).
//  When both memories are full, pulses o_load_done, which the top level ties to the matmul i_start.
// PARAMETERS
//  MUL_DATAWIDTH  8  element width (bits) of weights and activations
//  NUM_ROWS       4  array rows = elements per input-memory row
//  NUM_COLS       4  array cols = elements per weight-memory row
//  MEM_ROWS       8  entries per memory; address width $clog2(MEM_ROWS)
// PORTS
//  clk            in   1                         clock, all state on rising edge
//  rst_n          in   1                         asynchronous, active-low reset
//  i_load_start   in   1                         1-cycle pulse: begin a full load (ignored unless IDLE)
//  s_valid        in   1                         stream element valid
//  s_ready        out  1                         stream element ready
//  s_data         in   MUL_DATAWIDTH             stream element
//  o_weight_cenb  out  1                         weight mem chip enable, active-low
//  o_weight_wenb  out  1                         weight mem write enable, active-low
//  o_weight_addr  out  $clog2(MEM_ROWS)          weight mem row address
//  o_weight_data  out  MUL_DATAWIDTH*NUM_COLS    weight mem write row
//  o_input_cenb / o_input_wenb / o_input_addr / o_input_data   same signals for input mem,
//                                                data width MUL_DATAWIDTH*NUM_ROWS
//  o_busy         out  1                         high in LOAD_W/LOAD_I
//  o_load_done    out  1                         1-cycle pulse after last input row is written
//  o_checksum     out  16                        only with SA_LOADER_CHECKSUM_EN
// BEHAVIOUR
//  Reset values: FSM=IDLE; counters 0; s_ready=0; o_busy=0; o_load_done=0; all cenb/wenb=1.
//    addr/data outputs=0; o_checksum=0.
//  FSM: IDLE -(i_load_start)-> LOAD_W -(last weight element accepted)-> LOAD_I
//    -(last input element accepted)-> DONE -> IDLE (unconditional, 1 cycle).
//  s_ready=1 in LOAD_W/LOAD_I, 0 in IDLE/DONE. Element accepted when s_valid&&s_ready.
//    No bubbles: sustained throughput is 1 element/cycle, including across row and memory boundaries.
//  Packing: k-th accepted element of a row occupies bits [MUL_DATAWIDTH*(k+1)-1 -: MUL_DATAWIDTH].
//    Element 0 is in the LSBs (lane 0).
//  Lanes 0..N-2 are held in a row buffer. Acceptance of lane N-1 makes the write combinational that cycle:
//    cenb=0, wenb=0, addr=row counter, data={s_data, buffer}. The memory captures it on the same edge.
//    The row counter increments on that edge.
//  At most one memory has cenb=0 in any cycle; cenb/wenb are 1 in all other cycles.
//  Row counter wraps MEM_ROWS-1 -> 0 on the last row of each memory; lane counter wraps N-1 -> 0.
//  Stalls: s_valid=0 holds all counters and buffer; no write is issued.
//  i_load_start while busy or in DONE is ignored. i_load_start in the DONE cycle is not queued.
//  Reset mid-load: returns to the reset state immediately. Memory contents are undefined until a full reload.
//  Sequence length is fixed: MEM_ROWS*NUM_COLS weights, then MEM_ROWS*NUM_ROWS inputs. No length field, no last.
// CONFIGURATION
//  SA_LOADER_CHECKSUM_EN defined:
//    o_checksum = 16-bit wrapping sum of all accepted elements, zero-extended (unsigned).
//    Cleared when i_load_start is taken in IDLE; valid and stable from the o_load_done pulse until the next start.
//  Undefined: no o_checksum port and no adder logic. Everything else is identical.
// STRUCTURE
//  sa_pkg: typedef enum logic [1:0] {LD_IDLE, LD_LOAD_W, LD_LOAD_I, LD_DONE} sa_load_state_t;
//    localparam SA_CHECKSUM_W = 16.
//  Sub-module sa_row_packer #(DATAWIDTH, LANES, ROWS): lane counter, row counter, row buffer;
//    outputs a write strobe, address, data and a last-row flag.
//    Instantiated twice: LANES=NUM_COLS for weights, LANES=NUM_ROWS for inputs.
//    The top-level FSM gates each instance's accept with its state.
// TESTING (NUM_ROWS=NUM_COLS=4, MEM_ROWS=8, MUL_DATAWIDTH=8)
//  1. Pulse start; stream 0x01..0x40 with s_valid=1 every cycle.
//     -> weight row0=0x04030201, row7=0x201F1E1D; input row0=0x24232221, row7=0x403F3E3D.
//     -> o_load_done exactly 1 cycle after element 0x40 is accepted; 64 elements accepted in 64 cycles.
//  2. Same data, s_valid toggling 1/0.
//     -> identical memory contents; exactly 16 write strobes; never two cenb=0 in one cycle.
//  3. s_valid=1 while IDLE -> s_ready=0, no writes. Repeated i_load_start mid-load -> ignored, addresses continue.
//  4. rst_n low after 20 elements -> all outputs at reset values that cycle.
//     -> restart, stream 0x01..0x40: weight row0=0x04030201 (counters restarted).
//  5. (SA_LOADER_CHECKSUM_EN) stream 0x01..0x40 -> o_checksum=0x0820.
//     -> stream 64x 0xFF on the next load -> o_checksum=0x3FC0.
//  6. Two back-to-back loads, start pulsed in the cycle after done.
//     -> second load overwrites all 16 rows; second o_load_done pulse seen.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array memory loader.
package sa_pkg;
  typedef enum logic [1:0] {LD_IDLE, LD_LOAD_W, LD_LOAD_I, LD_DONE} sa_load_state_t;
  localparam int SA_CHECKSUM_W = 16;
endpackage

// File: rtl/sa_row_packer.sv
// Packs an element stream into LANES-wide rows; the write for a row is issued
// combinationally in the cycle its last lane is accepted.
module sa_row_packer #(
  parameter int DATAWIDTH = 8,
  parameter int LANES     = 4,
  parameter int ROWS      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         accept,
  input  logic [DATAWIDTH-1:0]         data,
  output logic                         wr,
  output logic [$clog2(ROWS)-1:0]      addr,
  output logic [DATAWIDTH*LANES-1:0]   wdata,
  output logic                         last_row
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int RW = $clog2(ROWS);

  logic [LW-1:0]                      lane_q;
  logic [RW-1:0]                      row_q;
  logic [LANES-2:0][DATAWIDTH-1:0]    row_buf;
  logic                               lane_last;

  assign lane_last = (lane_q == LW'(LANES-1));
  assign wr        = accept && lane_last;
  assign last_row  = (row_q == RW'(ROWS-1));
  // Outputs are forced to zero outside a write so idle buses are quiet.
  assign addr      = wr ? row_q : '0;
  assign wdata     = wr ? {data, row_buf} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lane_q <= '0;
    else if (accept) lane_q <= lane_last ? '0 : lane_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  row_q <= '0;
    else if (wr) row_q <= last_row ? '0 : row_q + 1'b1;
  end

  for (genvar g = 0; g < LANES-1; g++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              row_buf[g] <= '0;
      else if (accept && lane_q == LW'(g))     row_buf[g] <= data;
    end
  end
endmodule

// File: rtl/sa_mem_loader.sv
// Fill stage: streams weights then inputs into row memories, pulses o_load_done.
// Optional running checksum of accepted elements with SA_LOADER_CHECKSUM_EN.
module sa_mem_loader
  import sa_pkg::*;
#(
  parameter int MUL_DATAWIDTH = 8,
  parameter int NUM_ROWS      = 4,
  parameter int NUM_COLS      = 4,
  parameter int MEM_ROWS      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_load_start,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [MUL_DATAWIDTH-1:0]             s_data,
  output logic                                 o_weight_cenb,
  output logic                                 o_weight_wenb,
  output logic [$clog2(MEM_ROWS)-1:0]          o_weight_addr,
  output logic [MUL_DATAWIDTH*NUM_COLS-1:0]    o_weight_data,
  output logic                                 o_input_cenb,
  output logic                                 o_input_wenb,
  output logic [$clog2(MEM_ROWS)-1:0]          o_input_addr,
  output logic [MUL_DATAWIDTH*NUM_ROWS-1:0]    o_input_data,
  output logic                                 o_busy,
  output logic                                 o_load_done
`ifdef SA_LOADER_CHECKSUM_EN
  ,
  output logic [SA_CHECKSUM_W-1:0]             o_checksum
`endif
);
  sa_load_state_t state_q, state_d;
  logic acc_w, acc_i;
  logic w_wr, i_wr, w_last_row, i_last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE:   if (i_load_start)            state_d = LD_LOAD_W;
      LD_LOAD_W: if (w_wr && w_last_row)      state_d = LD_LOAD_I;
      LD_LOAD_I: if (i_wr && i_last_row)      state_d = LD_DONE;
      LD_DONE:                                state_d = LD_IDLE;
      default:                                state_d = LD_IDLE;
    endcase
  end

  always_comb begin
    s_ready     = 1'b0;
    o_busy      = 1'b0;
    o_load_done = 1'b0;
    acc_w       = 1'b0;
    acc_i       = 1'b0;
    case (state_q)
      LD_LOAD_W: begin s_ready = 1'b1; o_busy = 1'b1; acc_w = s_valid; end
      LD_LOAD_I: begin s_ready = 1'b1; o_busy = 1'b1; acc_i = s_valid; end
      LD_DONE:   o_load_done = 1'b1;
      default:   ;
    endcase
  end

  sa_row_packer #(.DATAWIDTH(MUL_DATAWIDTH), .LANES(NUM_COLS), .ROWS(MEM_ROWS)) u_weight (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (acc_w),
    .data     (s_data),
    .wr       (w_wr),
    .addr     (o_weight_addr),
    .wdata    (o_weight_data),
    .last_row (w_last_row)
  );

  sa_row_packer #(.DATAWIDTH(MUL_DATAWIDTH), .LANES(NUM_ROWS), .ROWS(MEM_ROWS)) u_input (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (acc_i),
    .data     (s_data),
    .wr       (i_wr),
    .addr     (o_input_addr),
    .wdata    (o_input_data),
    .last_row (i_last_row)
  );

  // Packers accept in mutually exclusive states, so at most one cenb is low.
  assign o_weight_cenb = ~w_wr;
  assign o_weight_wenb = ~w_wr;
  assign o_input_cenb  = ~i_wr;
  assign o_input_wenb  = ~i_wr;

`ifdef SA_LOADER_CHECKSUM_EN
  logic [SA_CHECKSUM_W-1:0] csum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  csum_q <= '0;
    else if (state_q == LD_IDLE && i_load_start) csum_q <= '0;
    else if (s_valid && s_ready)                 csum_q <= csum_q + SA_CHECKSUM_W'(s_data);
  end
  assign o_checksum = csum_q;
`endif
endmodule

// File: tb/tb_sa_mem_loader.sv
// Randomized bench for sa_mem_loader; memories and expected rows are modelled
// from the stream contents. Define SA_LOADER_CHECKSUM_EN to also check o_checksum.
`timescale 1ns/1ps
module tb_sa_mem_loader;
  localparam int DW = 8, NR = 4, NC = 4, MR = 8, N = MR*NC + MR*NR;

  logic clk = 1'b0, rst_n = 1'b0, i_load_start = 1'b0, s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, o_weight_cenb, o_weight_wenb, o_input_cenb, o_input_wenb, o_busy, o_load_done;
  logic [$clog2(MR)-1:0] o_weight_addr, o_input_addr;
  logic [DW*NC-1:0] o_weight_data;
  logic [DW*NR-1:0] o_input_data;
`ifdef SA_LOADER_CHECKSUM_EN
  logic [15:0] o_checksum;
`endif

  sa_mem_loader #(.MUL_DATAWIDTH(DW), .NUM_ROWS(NR), .NUM_COLS(NC), .MEM_ROWS(MR)) dut (
    .clk(clk), .rst_n(rst_n), .i_load_start(i_load_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .o_weight_cenb(o_weight_cenb), .o_weight_wenb(o_weight_wenb),
    .o_weight_addr(o_weight_addr), .o_weight_data(o_weight_data),
    .o_input_cenb(o_input_cenb), .o_input_wenb(o_input_wenb),
    .o_input_addr(o_input_addr), .o_input_data(o_input_data),
    .o_busy(o_busy), .o_load_done(o_load_done)
`ifdef SA_LOADER_CHECKSUM_EN
    , .o_checksum(o_checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Memory model: sampled at negedge, equal to what the next posedge captures.
  logic [DW*NC-1:0] wmem [MR];
  logic [DW*NR-1:0] imem [MR];
  int ncyc = 0, w_wr = 0, i_wr = 0, both_low = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
  always @(negedge clk) begin
    ncyc++;
    if (!o_weight_cenb && !o_input_cenb) both_low++;
    if (!o_weight_cenb && !o_weight_wenb) begin w_wr++; wmem[o_weight_addr] = o_weight_data; end
    if (!o_input_cenb && !o_input_wenb)   begin i_wr++; imem[o_input_addr]  = o_input_data;  end
    if (s_valid && s_ready) acc_cyc = ncyc;
    if (o_load_done) begin done_cnt++; done_cyc = ncyc; end
  end

  logic [DW-1:0] stim [N];
  task automatic fill(input int kind);
    for (int i = 0; i < N; i++)
      stim[i] = (kind == 0) ? DW'(i+1) : (kind == 1) ? DW'($urandom) : 8'hFF;
  endtask

  function automatic logic [31:0] exp_row(input int base);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) r = r | (32'(stim[base+k]) << (8*k));
    return r;
  endfunction

  function automatic logic [15:0] exp_sum();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(stim[i]);
    return 16'(s);
  endfunction

  task automatic check_mems(input string tag);
    for (int r = 0; r < MR; r++) begin
      chk($sformatf("%s_w%0d", tag, r), wmem[r], exp_row(r*NC));
      chk($sformatf("%s_i%0d", tag, r), imem[r], exp_row(MR*NC + r*NR));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rst_ready"}, s_ready, 0);
    chk({tag, "_rst_busy"}, o_busy, 0);
    chk({tag, "_rst_done"}, o_load_done, 0);
    chk({tag, "_rst_en"}, {o_weight_cenb, o_weight_wenb, o_input_cenb, o_input_wenb}, 4'hF);
    chk({tag, "_rst_addr"}, {o_weight_addr, o_input_addr}, 0);
    chk({tag, "_rst_data"}, {o_weight_data, o_input_data}, 0);
`ifdef SA_LOADER_CHECKSUM_EN
    chk({tag, "_rst_csum"}, o_checksum, 0);
`endif
  endtask

  // Called at posedge+1 in IDLE.
  task automatic start_load();
    i_load_start = 1'b1;
    @(posedge clk); #1;
    i_load_start = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: toggling, 2: random valid plus stray start pulses.
  task automatic run_load(input int mode, input int limit, output int cyc);
    int idx = 0;
    cyc = 0;
    while (idx < limit && cyc < 4000) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      i_load_start = (mode == 2) && ($urandom_range(0, 5) == 0);
      s_data = stim[idx];
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    i_load_start = 1'b0;
    if (idx < limit) chk("stream_timeout", idx, limit);
  endtask

  task automatic full_load(input int mode, input string tag);
    int w0 = w_wr, i0 = i_wr, d0 = done_cnt, b0 = both_low, cyc;
    start_load();
    chk({tag, "_busy"}, {o_busy, s_ready}, 2'b11);
    run_load(mode, N, cyc);
    // Now in the DONE cycle: a start here must be dropped.
    i_load_start = 1'b1;
    @(posedge clk); #1;
    i_load_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done_start_dropped"}, {o_busy, s_ready}, 0);
    chk({tag, "_wwr"}, w_wr - w0, MR);
    chk({tag, "_iwr"}, i_wr - i0, MR);
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    chk({tag, "_done_lat"}, done_cyc - acc_cyc, 1);
    chk({tag, "_one_cenb"}, both_low - b0, 0);
    if (mode == 0) chk({tag, "_cycles"}, cyc, N);
    check_mems(tag);
`ifdef SA_LOADER_CHECKSUM_EN
    chk({tag, "_csum"}, o_checksum, exp_sum());
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, w0, i0, d0;
    #1;
    chk_reset("init");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle: valid without start is not accepted.
    w0 = w_wr; i0 = i_wr;
    s_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_ready", s_ready, 0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("idle_no_wr", (w_wr - w0) + (i_wr - i0), 0);

    // Sequential data, full rate; literal rows.
    fill(0);
    full_load(0, "seq");
    chk("seq_w0_lit", wmem[0], 32'h04030201);
    chk("seq_w7_lit", wmem[7], 32'h201F1E1D);
    chk("seq_i0_lit", imem[0], 32'h24232221);
    chk("seq_i7_lit", imem[7], 32'h403F3E3D);
`ifdef SA_LOADER_CHECKSUM_EN
    chk("seq_csum_lit", o_checksum, 16'h0820);
`endif

    // Toggling valid, then random valid with stray starts, random data.
    full_load(1, "tog");
    fill(1);
    full_load(2, "rnd");
    fill(1);
    full_load(2, "rnd2");

    fill(2);
    full_load(0, "ff");
`ifdef SA_LOADER_CHECKSUM_EN
    chk("ff_csum_lit", o_checksum, 16'h3FC0);
`endif

    // Reset after 20 elements, then restart from scratch.
    fill(0);
    start_load();
    run_load(0, 20, cyc);
    s_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    full_load(0, "after_rst");
    chk("after_rst_w0_lit", wmem[0], 32'h04030201);

    // Back-to-back: start in the IDLE cycle right after DONE.
    d0 = done_cnt; w0 = w_wr; i0 = i_wr;
    fill(1);
    start_load();
    run_load(0, N, cyc);
    @(posedge clk); #1;
    fill(1);
    start_load();
    chk("b2b_busy", o_busy, 1);
    run_load(2, N, cyc);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_done_cnt", done_cnt - d0, 2);
    chk("b2b_writes", (w_wr - w0) + (i_wr - i0), 4*MR);
    check_mems("b2b");
    chk("never_two_cenb", both_low, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
